// File: rtl/addsub_arbiter.sv
// Round-robin front end that shares one combinational par_addsub between two requesters.
// Optional signed-overflow capture is compiled in with `define ADDSUB_ARB_OVF_EN.
module addsub_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         op0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         op1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res,
  output logic         cout,
  output logic         ovf,
  output logic         busy,
  output logic [W-1:0] au_a,
  output logic [W-1:0] au_b,
  output logic         au_c,
  input  logic [W-1:0] au_s,
  input  logic         au_d,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_ptr;
  logic         r_owner;
  logic         r_gnt0;
  logic         r_gnt1;
  logic         r_done0;
  logic         r_done1;
  logic [W-1:0] r_res;
  logic         r_cout;
  logic [W-1:0] r_au_a;
  logic [W-1:0] r_au_b;
  logic         r_au_c;

  logic w_any;
  logic w_pick1;

  // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
  assign w_any   = req0 | req1;
  assign w_pick1 = req1 & (~req0 | r_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_au_a  <= '0;
      r_au_b  <= '0;
      r_au_c  <= 1'b0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_au_a  <= w_pick1 ? a1 : a0;
            r_au_b  <= w_pick1 ? b1 : b0;
            r_au_c  <= w_pick1 ? op1 : op0;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_owner <= w_pick1;
            r_ptr   <= ~w_pick1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res   <= au_s;
          r_cout  <= au_d;
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
          r_state <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ADDSUB_ARB_OVF_EN
  logic r_ovf;
  logic w_ovf_next;

  // Subtract overflows only when operand signs differ; add only when they match.
  always_comb begin
    w_ovf_next = 1'b0;
    if (r_au_c)
      w_ovf_next = (r_au_a[W-1] != r_au_b[W-1]) && (au_s[W-1] != r_au_a[W-1]);
    else
      w_ovf_next = (r_au_a[W-1] == r_au_b[W-1]) && (au_s[W-1] != r_au_a[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (r_state == ST_EXEC)
      r_ovf <= w_ovf_next;
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign res       = r_res;
  assign cout      = r_cout;
  assign au_a      = r_au_a;
  assign au_b      = r_au_b;
  assign au_c      = r_au_c;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a behavioural stand-in for the par_addsub unit.
module tb_addsub_arbiter;
  localparam int W = 4;

`ifdef ADDSUB_ARB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         req0, req1, op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1;
  logic [W-1:0] res;
  logic         cout, ovf, busy;
  logic [W-1:0] au_a, au_b, au_s;
  logic         au_c, au_d;
  logic [1:0]   dbg_state;
  logic [W:0]   unit_sum;

  int total = 0;
  int bad   = 0;

  addsub_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .cout(cout), .ovf(ovf), .busy(busy),
    .au_a(au_a), .au_b(au_b), .au_c(au_c),
    .au_s(au_s), .au_d(au_d), .dbg_state(dbg_state)
  );

  // par_addsub stand-in: S/D = A+B, or A+~B+1 when C is set.
  always_comb begin
    unit_sum = '0;
    if (au_c)
      unit_sum = {1'b0, au_a} + {1'b0, ~au_b} + 5'd1;
    else
      unit_sum = {1'b0, au_a} + {1'b0, au_b};
  end
  assign au_s = unit_sum[W-1:0];
  assign au_d = unit_sum[W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic op);
    if (sel) begin
      req1 = 1'b1; a1 = a; b1 = b; op1 = op;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b; op0 = op;
    end
  endtask

  // From grant cycle onward: check grant, then done/result, then return to IDLE.
  task automatic serve(input string tag, input logic sel, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic op, input logic [W-1:0] e_res,
                       input logic e_cout, input logic e_ovf_raw);
    @(posedge clk); #1;
    chk({tag, "_gnt"}, {6'd0, gnt1, gnt0}, sel ? 8'd2 : 8'd1);
    chk({tag, "_busy_g"}, {7'd0, busy}, 8'd1);
    chk({tag, "_au"}, {au_c, 3'd0, au_a}, {op, 3'd0, a});
    chk({tag, "_au_b"}, {4'd0, au_b}, {4'd0, b});
    if (sel) req1 = 1'b0; else req0 = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done"}, {6'd0, done1, done0}, sel ? 8'd2 : 8'd1);
    chk({tag, "_gnt_off"}, {6'd0, gnt1, gnt0}, 8'd0);
    chk({tag, "_res"}, {4'd0, res}, {4'd0, e_res});
    chk({tag, "_cout"}, {7'd0, cout}, {7'd0, e_cout});
    chk({tag, "_ovf"}, {7'd0, ovf}, {7'd0, e_ovf_raw & OVF_ON});
    @(posedge clk); #1;
    chk({tag, "_done_off"}, {6'd0, done1, done0}, 8'd0);
    chk({tag, "_idle"}, {6'd0, dbg_state}, 8'd0);
  endtask

  task automatic single(input string tag, input logic sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic op, input logic [W-1:0] e_res,
                        input logic e_cout, input logic e_ovf_raw);
    @(negedge clk);
    drive(sel, a, b, op);
    serve(tag, sel, a, b, op, e_res, e_cout, e_ovf_raw);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {gnt0, gnt1, done0, done1, busy, cout, ovf, au_c}, 8'd0);
    chk("rst_res", {res, au_a}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // No request: stays idle.
    @(posedge clk); #1;
    chk("idle_noreq", {5'd0, busy, dbg_state}, 8'd0);

    single("add0", 1'b0, 4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b1);
    single("sub1", 1'b1, 4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0);

    // Fresh reset so the pointer starts at requester 0 for the simultaneous pairs.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    drive(1'b0, 4'b0010, 4'b0001, 1'b1);
    drive(1'b1, 4'b0110, 4'b0011, 1'b0);
    serve("pairA_r0", 1'b0, 4'b0010, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0);
    serve("pairA_r1", 1'b1, 4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1);

    @(negedge clk);
    drive(1'b0, 4'b1000, 4'b0001, 1'b1);
    drive(1'b1, 4'b0001, 4'b0010, 1'b0);
    serve("pairB_r0", 1'b0, 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);
    serve("pairB_r1", 1'b1, 4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0);

    single("max_add", 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
    single("wrap_add", 1'b0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Reset mid-operation: previous res was 0000, so load a nonzero one first.
    single("pre_rst", 1'b0, 4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'b0110, 4'b0001, 1'b0);
    @(posedge clk); #1;
    chk("rst_exec_state", {6'd0, dbg_state}, 8'd1);
    req0 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_outs", {gnt0, gnt1, done0, done1, busy, cout, ovf, au_c}, 8'd0);
    chk("rst_exec_res", {res, au_a}, 8'd0);
    chk("rst_exec_aub", {dbg_state, 2'd0, au_b}, 8'd0);
    @(posedge clk); #1;
    chk("rst_exec_nodone", {6'd0, done1, done0}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    single("post_rst", 1'b0, 4'b0101, 4'b0001, 1'b0, 4'b0110, 1'b0, 1'b0);
    single("ovf_add", 1'b0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
